// File: rtl/clock_period_meter.sv
// -----------------------------------------------------------------------------
// clock_period_meter
//
// Measures a slow square wave (for example a divided clock or an external
// tick) in the system clock domain. It reports the period and the high time
// of the wave in system-clock cycles, and flags loss of signal when no rising
// edge arrives for TIMEOUT_CYCLES cycles.
//
// Parameters
//   CNT_W          width of the period/high-time counters and outputs
//   SYNC_STAGES    synchronizer depth on sig_in (>= 2)
//   TIMEOUT_CYCLES cycles without a rising edge before timeout (< 2**CNT_W)
//
// Ports
//   clk        system clock, all logic on its rising edge
//   rst_n      asynchronous active-low reset
//   sig_in     slow square wave, asynchronous to clk
//   clear      synchronous restart, active-high
//   period     clk cycles between the last two sig_in rising edges
//   high_time  clk cycles sig_in was high within that period
//   meas_valid one-cycle pulse when period/high_time update
//   locked     high once one full period is measured and no timeout since
//   timeout    sticky loss-of-signal flag, cleared by the next rising edge
// -----------------------------------------------------------------------------
module clock_period_meter #(
    parameter int          CNT_W          = 32,
    parameter int          SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEAS,
        S_TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

    // -------------------------------------------------------------------------
    // Input synchronizer and rising-edge detector. These keep running through
    // clear so that a restart never fabricates an edge out of stale history.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync;
    logic                   rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbour; a blocking
            // assignment here would collapse the synchronizer into one stage.
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync;
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];
    assign rise = sync & ~prev_q;

    // -------------------------------------------------------------------------
    // Measurement FSM: state register and datapath registers
    // -------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_d, high_time_d;
    logic             meas_valid_d, locked_d, timeout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hcnt_q     <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hcnt_q     <= hcnt_d;
            period     <= period_d;
            high_time  <= high_time_d;
            meas_valid <= meas_valid_d;
            locked     <= locked_d;
            timeout    <= timeout_d;
        end
    end

    // Next-state and next-output logic. Priority: clear > rise > timeout.
    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path
        // through the case statement leaves one unassigned and infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        hcnt_d       = hcnt_q;
        period_d     = period;
        high_time_d  = high_time;
        meas_valid_d = 1'b0;
        locked_d     = locked;
        timeout_d    = timeout;

        if (clear) begin
            // Restart from scratch; a coincident rise is deliberately dropped.
            state_d     = S_IDLE;
            cnt_d       = '0;
            hcnt_d      = '0;
            period_d    = '0;
            high_time_d = '0;
            locked_d    = 1'b0;
            timeout_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // First edge only opens a period; nothing to report yet.
                    if (rise) begin
                        state_d = S_MEAS;
                        cnt_d   = CNT_ONE;
                        hcnt_d  = CNT_ONE;
                    end
                end

                S_MEAS: begin
                    if (rise) begin
                        // The rise cycle itself is cycle 1 of the new period.
                        period_d     = cnt_q;
                        high_time_d  = hcnt_q;
                        meas_valid_d = 1'b1;
                        locked_d     = 1'b1;
                        cnt_d        = CNT_ONE;
                        hcnt_d       = CNT_ONE;
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        // Counter parks here, so it can never wrap.
                        state_d     = S_TIMEOUT;
                        timeout_d   = 1'b1;
                        locked_d    = 1'b0;
                        period_d    = '0;
                        high_time_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (sync) begin
                            hcnt_d = hcnt_q + CNT_ONE;
                        end
                    end
                end

                S_TIMEOUT: begin
                    // Signal is back, but a full period is needed to relock.
                    if (rise) begin
                        state_d   = S_MEAS;
                        timeout_d = 1'b0;
                        cnt_d     = CNT_ONE;
                        hcnt_d    = CNT_ONE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule
